mem_sequencer: RTL and testbench
================================

// Module: mem_sequencer
// PURPOSE
//  CPU-side initiator for the datapath memory port: fetch, load, store, push, pop.
//  Accepts one request at a time on a valid/ready handshake and drives the memory-side signals.
//  The memory block has a one-cycle registered read, so the sequencer captures returned data and
//  answers on a valid/ready response channel. Owns the stack pointer. Sits between control FSM and memory.
// PARAMETERS
//  WIDTH        16      address and data width
//  STACK_BASE   16'h0000 stack_pointer reset value
//  STACK_LIMIT  16'hFFFF highest legal push address (used only with bounds check)
// PORTS
//  clock               in   1      rising-edge clock
//  reset               in   1      synchronous, active-high reset
//  req_valid           in   1      request present
//  req_ready           out  1      sequencer can accept (high only in IDLE)
//  req_op              in   3      0 FETCH,1 LOAD,2 STORE,3 PUSH,4 POP; 5-7 NOP
//  req_addr            in   WIDTH  PC for FETCH, address for LOAD/STORE
//  req_data            in   WIDTH  store/push data
//  rsp_valid           out  1      response held until rsp_ready
//  rsp_ready           in   1      consumer accepts response
//  rsp_op              out  3      op of the response
//  rsp_data            out  WIDTH  read data, or written data for STORE/PUSH
//  stack_pointer       out  WIDTH  next free stack slot
//  fault               out  1      sticky stack fault (0 unless MEM_SEQ_STACK_CHECK_EN)
//  program_counter     out  WIDTH  to memory instruction port
//  address             out  WIDTH  to memory data/stack port
//  value               out  WIDTH  store data to memory
//  memory_store_enable out  1      main memory write strobe
//  stack_store_enable  out  1      stack write strobe
//  current_instruction in   WIDTH  from memory, valid one edge after program_counter sampled
//  at_memory           in   WIDTH  from memory, same latency
//  at_stack            in   WIDTH  from memory, same latency
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1; rsp_valid=0, rsp_data=0, rsp_op=0.
//  Reset: program_counter, address and value = 0; both store enables = 0.
//  Reset: stack_pointer=STACK_BASE, fault=0.
//  Reset mid-operation aborts the operation: no strobe after the reset edge, in-flight response dropped.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE. Request accepted on the edge where req_valid&&req_ready (edge N).
//  ISSUE (N..N+1): memory-side outputs registered from the request.
//   Store enables are high for exactly this one cycle; the memory samples at edge N+1.
//  WAIT (N+1..N+2): memory data now valid; captured into rsp_data at edge N+2.
//  RESP: rsp_valid=1 from edge N+2 and held with stable rsp_data/rsp_op until rsp_ready.
//   Handshake edge returns to IDLE. Next request can be accepted at the earliest on the following edge.
//  FETCH: program_counter=req_addr; rsp_data=current_instruction.
//  LOAD: address=req_addr; rsp_data=at_memory.
//  STORE: address=req_addr, value=req_data, memory_store_enable; rsp_data=req_data.
//  PUSH: address=stack_pointer, value=req_data, stack_store_enable; stack_pointer+1 at edge N+1; rsp_data=req_data.
//  POP: address=stack_pointer-1; stack_pointer-1 at edge N+1; rsp_data=at_stack.
//  NOP: no strobe, no SP change; responds with rsp_data=0 after the same 3-state sequence.
//  Arithmetic: stack_pointer is modulo 2^WIDTH; wraps FFFF->0000 on push and 0000->FFFF on pop when unchecked.
//  address/program_counter hold their last value outside ISSUE; strobes are 0 outside ISSUE.
// CONFIGURATION
//  MEM_SEQ_STACK_CHECK_EN defined: PUSH with stack_pointer>STACK_LIMIT, or POP with stack_pointer==STACK_BASE,
//   is a fault: no strobe, SP unchanged, rsp_data=0, fault set and held until reset; response still issued.
//  MEM_SEQ_STACK_CHECK_EN undefined: no check; SP wraps; fault tied 0.
// STRUCTURE
//  Package mem_seq_pkg: op codes (OP_FETCH..OP_POP), state encoding, WIDTH default.
//  Sub-module mem_seq_sp: stack pointer register, inc/dec, bounds compare; reports fault.
// TESTING
//  Reset, then FETCH addr 0x0010 with memory word 0xABCD:
//   rsp_valid rises at edge N+2, rsp_data=0xABCD, rsp_op=0.
//  STORE 0x1234 to 0x0020, then LOAD 0x0020:
//   memory_store_enable high one cycle; the LOAD response is 0x1234.
//  PUSH 0x1111, PUSH 0x2222, POP, POP:
//   SP goes 0->1->2->1->0; pops return 0x2222 then 0x1111.
//  Hold rsp_ready=0 for 5 cycles:
//   rsp_valid/rsp_data stable; req_ready=0 throughout; no memory strobe.
//  POP at SP=0 with MEM_SEQ_STACK_CHECK_EN: fault=1, SP stays 0, rsp_data=0.
//  POP at SP=0 without the macro: SP becomes 0xFFFF and address=0xFFFF.
//  Assert reset during ISSUE of a STORE: no strobe after the reset edge; rsp_valid=0; SP=STACK_BASE.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared op codes, state encoding and default width for the memory sequencer.
package mem_seq_pkg;

    localparam int unsigned SEQ_WIDTH = 16;
    localparam int unsigned OP_W      = 3;

    typedef enum logic [OP_W-1:0] {
        OP_FETCH = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_seq_if.sv
// Request/response handshake bundle between the control FSM and the sequencer.
interface mem_seq_if
    import mem_seq_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH
);
    logic             req_valid;
    logic             req_ready;
    logic [OP_W-1:0]  req_op;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [OP_W-1:0]  rsp_op;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_op, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_op, rsp_data
    );
endinterface

// File: rtl/mem_seq_sp.sv
// Stack pointer register with increment/decrement and optional bounds fault.
// Bounds checking is enabled by defining MEM_SEQ_STACK_CHECK_EN.
module mem_seq_sp #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] STACK_BASE  = '0,
    parameter logic [WIDTH-1:0] STACK_LIMIT = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             fault_set,
    output logic [WIDTH-1:0] stack_pointer,
    output logic             fault,
    output logic             push_fault_c,
    output logic             pop_fault_c
);

    // Stack pointer update, modulo 2^WIDTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            stack_pointer <= STACK_BASE;
        end else if (inc) begin
            stack_pointer <= stack_pointer + WIDTH'(1);
        end else if (dec) begin
            stack_pointer <= stack_pointer - WIDTH'(1);
        end
    end

`ifdef MEM_SEQ_STACK_CHECK_EN
    assign push_fault_c = (stack_pointer > STACK_LIMIT);
    assign pop_fault_c  = (stack_pointer == STACK_BASE);

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (fault_set) begin
            fault <= 1'b1;
        end
    end
`else
    logic unused_check;
    assign unused_check = ^{STACK_LIMIT, fault_set};
    assign push_fault_c = 1'b0;
    assign pop_fault_c  = 1'b0;
    assign fault        = 1'b0;
`endif

endmodule

// File: rtl/mem_sequencer.sv
// CPU-side initiator for the datapath memory port: fetch, load, store, push, pop.
// Optional stack bounds checking via MEM_SEQ_STACK_CHECK_EN.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned      WIDTH       = SEQ_WIDTH,
    parameter logic [WIDTH-1:0] STACK_BASE  = '0,
    parameter logic [WIDTH-1:0] STACK_LIMIT = '1
) (
    input  logic             clock,
    input  logic             reset,
    mem_seq_if.slave         bus,
    output logic [WIDTH-1:0] stack_pointer,
    output logic             fault,
    output logic [WIDTH-1:0] program_counter,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] value,
    output logic             memory_store_enable,
    output logic             stack_store_enable,
    input  logic [WIDTH-1:0] current_instruction,
    input  logic [WIDTH-1:0] at_memory,
    input  logic [WIDTH-1:0] at_stack
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             bad_q, bad_d;
    logic [WIDTH-1:0] pc_d, addr_d, value_d, rsp_data_d;
    logic [OP_W-1:0]  rsp_op_d;
    logic             mse_d, sse_d, rsp_valid_d, req_ready_d;
    logic             push_fault_c, pop_fault_c;
    logic             sp_inc, sp_dec, sp_fault_set;

    assign sp_inc       = (state_q == ST_ISSUE) && (op_q == OP_PUSH) && !bad_q;
    assign sp_dec       = (state_q == ST_ISSUE) && (op_q == OP_POP)  && !bad_q;
    assign sp_fault_set = (state_q == ST_ISSUE) && bad_q;

    mem_seq_sp #(
        .WIDTH       (WIDTH),
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_sp (
        .clock         (clock),
        .reset         (reset),
        .inc           (sp_inc),
        .dec           (sp_dec),
        .fault_set     (sp_fault_set),
        .stack_pointer (stack_pointer),
        .fault         (fault),
        .push_fault_c  (push_fault_c),
        .pop_fault_c   (pop_fault_c)
    );

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            op_q                <= '0;
            wdata_q             <= '0;
            bad_q               <= 1'b0;
            program_counter     <= '0;
            address             <= '0;
            value               <= '0;
            memory_store_enable <= 1'b0;
            stack_store_enable  <= 1'b0;
            bus.req_ready       <= 1'b1;
            bus.rsp_valid       <= 1'b0;
            bus.rsp_op          <= '0;
            bus.rsp_data        <= '0;
        end else begin
            state_q             <= state_d;
            op_q                <= op_d;
            wdata_q             <= wdata_d;
            bad_q               <= bad_d;
            program_counter     <= pc_d;
            address             <= addr_d;
            value               <= value_d;
            memory_store_enable <= mse_d;
            stack_store_enable  <= sse_d;
            bus.req_ready       <= req_ready_d;
            bus.rsp_valid       <= rsp_valid_d;
            bus.rsp_op          <= rsp_op_d;
            bus.rsp_data        <= rsp_data_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        bad_d       = bad_q;
        pc_d        = program_counter;
        addr_d      = address;
        value_d     = value;
        mse_d       = 1'b0;
        sse_d       = 1'b0;
        rsp_valid_d = bus.rsp_valid;
        rsp_op_d    = bus.rsp_op;
        rsp_data_d  = bus.rsp_data;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    state_d = ST_ISSUE;
                    op_d    = bus.req_op;
                    wdata_d = bus.req_data;
                    bad_d   = 1'b0;
                    case (bus.req_op)
                        OP_FETCH: pc_d = bus.req_addr;
                        OP_LOAD:  addr_d = bus.req_addr;
                        OP_STORE: begin
                            addr_d  = bus.req_addr;
                            value_d = bus.req_data;
                            mse_d   = 1'b1;
                        end
                        OP_PUSH: begin
                            if (push_fault_c) begin
                                bad_d = 1'b1;
                            end else begin
                                addr_d  = stack_pointer;
                                value_d = bus.req_data;
                                sse_d   = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (pop_fault_c) begin
                                bad_d = 1'b1;
                            end else begin
                                addr_d = stack_pointer - WIDTH'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_op_d    = op_q;
                if (bad_q) begin
                    rsp_data_d = '0;
                end else begin
                    case (op_q)
                        OP_FETCH:         rsp_data_d = current_instruction;
                        OP_LOAD:          rsp_data_d = at_memory;
                        OP_STORE, OP_PUSH: rsp_data_d = wdata_q;
                        OP_POP:           rsp_data_d = at_stack;
                        default:          rsp_data_d = '0;
                    endcase
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Table-driven bench with a response scoreboard and a memory model for mem_sequencer.
module tb_mem_sequencer;

    logic        clock;
    logic        reset;
    logic [15:0] stack_pointer, program_counter, address, value;
    logic        fault, memory_store_enable, stack_store_enable;
    logic [15:0] current_instruction, at_memory, at_stack;

    mem_seq_if #(.WIDTH(16)) bus ();

    mem_sequencer #(
        .WIDTH       (16),
        .STACK_BASE  (16'h0000),
        .STACK_LIMIT (16'hFFFF)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .bus                 (bus),
        .stack_pointer       (stack_pointer),
        .fault               (fault),
        .program_counter     (program_counter),
        .address             (address),
        .value               (value),
        .memory_store_enable (memory_store_enable),
        .stack_store_enable  (stack_store_enable),
        .current_instruction (current_instruction),
        .at_memory           (at_memory),
        .at_stack            (at_stack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle registered-read memory with separate instruction, data and stack arrays.
    logic [15:0] imem [0:65535];
    logic [15:0] dmem [0:65535];
    logic [15:0] smem [0:65535];

    always @(posedge clock) begin
        current_instruction <= imem[program_counter];
        at_memory           <= dmem[address];
        at_stack            <= smem[address];
        if (memory_store_enable) dmem[address] <= value;
        if (stack_store_enable)  smem[address] <= value;
    end

    int mse_cnt = 0;
    int sse_cnt = 0;
    always @(negedge clock) begin
        if (memory_store_enable) mse_cnt <= mse_cnt + 1;
        if (stack_store_enable)  sse_cnt <= sse_cnt + 1;
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic [15:0] exp_addr;
        logic        chk_addr;
        int          exp_mse;
        int          exp_sse;
        logic [15:0] exp_sp;
        int          hold;
    } vec_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_req(input vec_t v);
        exp_t e_in, e_out;
        int   m0, s0, waitn;
        @(negedge clock);
        m0 = mse_cnt;
        s0 = sse_cnt;
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_addr  = v.addr;
        bus.req_data  = v.data;
        e_in.op   = v.op;
        e_in.data = v.exp_data;
        sb.push_back(e_in);
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("issue_req_ready", 32'(bus.req_ready), 32'd0);
        check("issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        if (v.chk_addr) begin
            if (v.op == 3'd0) check("issue_pc", 32'(program_counter), 32'(v.exp_addr));
            else              check("issue_addr", 32'(address), 32'(v.exp_addr));
        end
        @(negedge clock);
        check("wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clock);
        check("rsp_latency", 32'(bus.rsp_valid), 32'd1);
        waitn = 0;
        while (!bus.rsp_valid && waitn < 8) begin
            @(negedge clock);
            waitn++;
        end
        e_out = sb.pop_front();
        if (!bus.rsp_valid) begin
            check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
            return;
        end
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < v.hold; i++) begin
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_data", 32'(bus.rsp_data), 32'(e_out.data));
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clock);
        end
        check("rsp_data", 32'(bus.rsp_data), 32'(e_out.data));
        check("rsp_op", 32'(bus.rsp_op), 32'(e_out.op));
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("done_req_ready", 32'(bus.req_ready), 32'd1);
        check("sp", 32'(stack_pointer), 32'(v.exp_sp));
        check("mse_count", 32'(mse_cnt - m0), 32'(v.exp_mse));
        check("sse_count", 32'(sse_cnt - s0), 32'(v.exp_sse));
    endtask

    vec_t vecs [11];
    vec_t v;
    int   m1;

    initial begin
        vecs[0]  = '{3'd0, 16'h0010, 16'h0000, 16'hABCD, 16'h0010, 1'b1, 0, 0, 16'h0000, 0};
        vecs[1]  = '{3'd2, 16'h0020, 16'h1234, 16'h1234, 16'h0020, 1'b1, 1, 0, 16'h0000, 0};
        vecs[2]  = '{3'd1, 16'h0020, 16'h0000, 16'h1234, 16'h0020, 1'b1, 0, 0, 16'h0000, 5};
        vecs[3]  = '{3'd3, 16'h0000, 16'h1111, 16'h1111, 16'h0000, 1'b1, 0, 1, 16'h0001, 0};
        vecs[4]  = '{3'd3, 16'h0000, 16'h2222, 16'h2222, 16'h0001, 1'b1, 0, 1, 16'h0002, 0};
        vecs[5]  = '{3'd4, 16'h0000, 16'h0000, 16'h2222, 16'h0001, 1'b1, 0, 0, 16'h0001, 0};
        vecs[6]  = '{3'd4, 16'h0000, 16'h0000, 16'h1111, 16'h0000, 1'b1, 0, 0, 16'h0000, 0};
        vecs[7]  = '{3'd5, 16'h0033, 16'h9999, 16'h0000, 16'h0000, 1'b0, 0, 0, 16'h0000, 0};
        vecs[8]  = '{3'd2, 16'h0040, 16'hBEEF, 16'hBEEF, 16'h0040, 1'b1, 1, 0, 16'h0000, 2};
        vecs[9]  = '{3'd1, 16'h0040, 16'h0000, 16'hBEEF, 16'h0040, 1'b1, 0, 0, 16'h0000, 0};
        vecs[10] = '{3'd7, 16'h0055, 16'h7777, 16'h0000, 16'h0000, 1'b0, 0, 0, 16'h0000, 1};

        imem[16'h0010] = 16'hABCD;
        smem[16'hFFFF] = 16'h5A5A;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 16'h0000;
        bus.req_data  = 16'h0000;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
        check("rst_pc", 32'(program_counter), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_mse", 32'(memory_store_enable), 32'd0);
        check("rst_sse", 32'(stack_store_enable), 32'd0);
        check("rst_sp", 32'(stack_pointer), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) do_req(vecs[i]);
        check("fault_clear", 32'(fault), 32'd0);

        // POP from an empty stack.
`ifdef MEM_SEQ_STACK_CHECK_EN
        v = '{3'd4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, 0, 16'h0000, 0};
        do_req(v);
        check("pop_empty_fault", 32'(fault), 32'd1);
`else
        v = '{3'd4, 16'h0000, 16'h0000, 16'h5A5A, 16'hFFFF, 1'b1, 0, 0, 16'hFFFF, 0};
        do_req(v);
        check("pop_wrap_fault", 32'(fault), 32'd0);
        check("pop_wrap_addr_held", 32'(address), 32'h0000FFFF);
`endif

        // Reset asserted while a STORE is in ISSUE.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd2;
        bus.req_addr  = 16'h0050;
        bus.req_data  = 16'h4242;
        @(negedge clock);
        bus.req_valid = 1'b0;
        check("rst_mid_issue_mse", 32'(memory_store_enable), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_mse", 32'(memory_store_enable), 32'd0);
        check("rst_mid_sse", 32'(stack_store_enable), 32'd0);
        check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid_sp", 32'(stack_pointer), 32'd0);
        check("rst_mid_fault", 32'(fault), 32'd0);
        m1 = mse_cnt;
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_after_mse_count", 32'(mse_cnt - m1), 32'd0);
        check("rst_after_req_ready", 32'(bus.req_ready), 32'd1);

        // Normal operation resumes after the abort.
        v = '{3'd3, 16'h0000, 16'h3C3C, 16'h3C3C, 16'h0000, 1'b1, 0, 1, 16'h0001, 0};
        do_req(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
